// File: rtl/ipref_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ipref_mem_arbiter
//  Description : Shares the I$ memory request port between demand misses and
//                the stream-buffer prefetcher; steers returns by TID.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipref_mem_arbiter #(
    parameter int ADDR_W     = 56,
    parameter int DATA_W     = 128,
    parameter int TID_W      = 2,
    parameter int PF_TID     = 1,
    parameter int PFQ_DEPTH  = 4,
    parameter int MAX_PF_OUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              dmd_req_i,
    input  logic [ADDR_W-1:0] dmd_addr_i,
    input  logic [TID_W-1:0]  dmd_tid_i,
    output logic              dmd_ack_o,
    input  logic              pf_req_i,
    input  logic [ADDR_W-1:0] pf_addr_i,
    output logic              pf_drop_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [TID_W-1:0]  mem_tid_o,
    input  logic              mem_ack_i,
    input  logic              mem_rtrn_vld_i,
    input  logic [TID_W-1:0]  mem_rtrn_tid_i,
    input  logic [DATA_W-1:0] mem_rtrn_data_i,
    output logic              dmd_rtrn_vld_o,
    output logic              pf_rtrn_vld_o,
    output logic [DATA_W-1:0] rtrn_data_o
);

    localparam int c_PTR_W = (PFQ_DEPTH > 1) ? $clog2(PFQ_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(PFQ_DEPTH) + 1;
    localparam int c_OUT_W = $clog2(MAX_PF_OUT + 2);
    localparam int c_SUM_W = c_OUT_W + 2;

    localparam logic [c_OUT_W-1:0] c_OUT_MAX  = '1;
    localparam logic [TID_W-1:0]   c_PF_TID   = TID_W'(PF_TID);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(PFQ_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(PFQ_DEPTH);
    localparam logic [c_OUT_W:0]   c_PF_LIMIT = (c_OUT_W + 1)'(MAX_PF_OUT);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DMD  = 2'd1;
    localparam logic [1:0] c_ST_PF   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [TID_W-1:0]   r_mem_tid;
    logic               r_stale;
    logic [c_OUT_W-1:0] r_pf_out;
    logic [c_OUT_W-1:0] r_discard;

    logic [ADDR_W-1:0]  r_fifo [PFQ_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_fifo_ne, w_full, w_pf_room;
    logic w_pop, w_push, w_drop;
    logic w_dmd_ack, w_ack_pf;
    logic w_rtrn_pf, w_disc_dec, w_pf_dec;
    logic [c_PTR_W-1:0] w_wr_ptr_inc, w_rd_ptr_inc;
    logic [c_SUM_W-1:0] w_pf_sum, w_disc_sum;
    logic [c_OUT_W-1:0] w_pf_nxt, w_disc_nxt;

    assign w_fifo_ne = (r_count != '0);
    assign w_full    = (r_count == c_FULL);
    // The stale request in flight still occupies a slot against the cap.
    assign w_pf_room = (({1'b0, r_pf_out} + {{c_OUT_W{1'b0}}, r_stale}) < c_PF_LIMIT);

    assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dmd_ack   = 1'b0;
        w_ack_pf    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (dmd_req_i) begin
                    w_state_nxt = c_ST_DMD;
                end else if (w_fifo_ne && w_pf_room && !flush_i) begin
                    w_state_nxt = c_ST_PF;
                    w_pop       = 1'b1;
                end
            end
            c_ST_DMD: begin
                if (mem_ack_i) begin
                    w_dmd_ack   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_PF: begin
                if (mem_ack_i) begin
                    w_ack_pf    = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // A flush drops incoming pulses silently rather than reporting them as overflow.
    assign w_push = pf_req_i && !flush_i && (!w_full || w_pop);
    assign w_drop = pf_req_i && !flush_i && w_full && !w_pop;

    assign w_rtrn_pf  = mem_rtrn_vld_i && (mem_rtrn_tid_i == c_PF_TID);
    assign w_disc_dec = w_rtrn_pf && (r_discard != '0);
    assign w_pf_dec   = w_rtrn_pf && (r_discard == '0) && (r_pf_out != '0);

    always_comb begin
        w_pf_sum   = {2'b00, r_pf_out};
        w_disc_sum = {2'b00, r_discard};
        if (w_disc_dec) w_disc_sum = w_disc_sum - c_SUM_W'(1);
        if (w_pf_dec)   w_pf_sum   = w_pf_sum - c_SUM_W'(1);
        if (w_ack_pf) begin
            if (r_stale || flush_i) w_disc_sum = w_disc_sum + c_SUM_W'(1);
            else                    w_pf_sum   = w_pf_sum + c_SUM_W'(1);
        end
        if (flush_i) begin
            w_disc_sum = w_disc_sum + w_pf_sum;
            w_pf_sum   = '0;
        end
        w_pf_nxt   = (w_pf_sum > {2'b00, c_OUT_MAX})   ? c_OUT_MAX : w_pf_sum[c_OUT_W-1:0];
        w_disc_nxt = (w_disc_sum > {2'b00, c_OUT_MAX}) ? c_OUT_MAX : w_disc_sum[c_OUT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_tid  <= '0;
            r_stale    <= 1'b0;
            r_pf_out   <= '0;
            r_discard  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt != c_ST_IDLE);
            if (r_state == c_ST_IDLE && dmd_req_i) begin
                r_mem_addr <= dmd_addr_i;
                r_mem_tid  <= dmd_tid_i;
            end else if (w_pop) begin
                r_mem_addr <= r_fifo[r_rd_ptr];
                r_mem_tid  <= c_PF_TID;
            end
            if (w_ack_pf)
                r_stale <= 1'b0;
            else if (flush_i && r_state == c_ST_PF)
                r_stale <= 1'b1;
            r_pf_out  <= w_pf_nxt;
            r_discard <= w_disc_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset; the count qualifies every entry.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= pf_addr_i;
    end

    assign dmd_ack_o      = w_dmd_ack;
    assign pf_drop_o      = w_drop;
    assign mem_req_o      = r_mem_req;
    assign mem_addr_o     = r_mem_addr;
    assign mem_tid_o      = r_mem_tid;
    assign dmd_rtrn_vld_o = mem_rtrn_vld_i && (mem_rtrn_tid_i != c_PF_TID);
    assign pf_rtrn_vld_o  = w_pf_dec;
    assign rtrn_data_o    = mem_rtrn_data_i;

    a_dmd_tid_legal : assert property (@(posedge clk_i) disable iff (rst_i)
        dmd_req_i |-> (dmd_tid_i != c_PF_TID));

    a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_req_o && !mem_ack_i) |=> ($stable(mem_addr_o) && $stable(mem_tid_o)));

    a_pf_rtrn_expected : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_rtrn_pf && (r_discard == '0) && (r_pf_out == '0)));

endmodule
`default_nettype wire

// File: tb/tb_ipref_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipref_mem_arbiter
//  Description : Self-checking bench for ipref_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ipref_mem_arbiter;
    localparam int ADDR_W     = 56;
    localparam int DATA_W     = 128;
    localparam int TID_W      = 2;
    localparam int PF_TID     = 1;
    localparam int PFQ_DEPTH  = 4;
    localparam int MAX_PF_OUT = 4;
    localparam int DISC_SAT   = 7;

    logic              clk_i = 1'b0;
    logic              rst_i, flush_i, dmd_req_i, pf_req_i, mem_ack_i, mem_rtrn_vld_i;
    logic [ADDR_W-1:0] dmd_addr_i, pf_addr_i;
    logic [TID_W-1:0]  dmd_tid_i, mem_rtrn_tid_i;
    logic [DATA_W-1:0] mem_rtrn_data_i;
    logic              dmd_ack_o, pf_drop_o, mem_req_o, dmd_rtrn_vld_o, pf_rtrn_vld_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [TID_W-1:0]  mem_tid_o;
    logic [DATA_W-1:0] rtrn_data_o;

    always #5 clk_i = ~clk_i;

    ipref_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TID_W(TID_W), .PF_TID(PF_TID),
        .PFQ_DEPTH(PFQ_DEPTH), .MAX_PF_OUT(MAX_PF_OUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .dmd_req_i(dmd_req_i), .dmd_addr_i(dmd_addr_i), .dmd_tid_i(dmd_tid_i),
        .dmd_ack_o(dmd_ack_o), .pf_req_i(pf_req_i), .pf_addr_i(pf_addr_i),
        .pf_drop_o(pf_drop_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_tid_o(mem_tid_o), .mem_ack_i(mem_ack_i), .mem_rtrn_vld_i(mem_rtrn_vld_i),
        .mem_rtrn_tid_i(mem_rtrn_tid_i), .mem_rtrn_data_i(mem_rtrn_data_i),
        .dmd_rtrn_vld_o(dmd_rtrn_vld_o), .pf_rtrn_vld_o(pf_rtrn_vld_o),
        .rtrn_data_o(rtrn_data_o)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: queued prefetch addresses, outstanding
    // counts, and the one request currently offered to memory.
    logic [ADDR_W-1:0] m_q[$];
    int                m_pf_out, m_discard;
    bit                m_stale;
    int                m_busy;            // 0 none, 1 demand, 2 prefetch
    logic [ADDR_W-1:0] m_addr;
    logic [TID_W-1:0]  m_tid;
    bit                last_dack;

    typedef struct {
        logic [TID_W-1:0]  tid;
        logic [DATA_W-1:0] data;
        bit                exp_d;
        bit                exp_p;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pf_out  = 0;
        m_discard = 0;
        m_stale   = 0;
        m_busy    = 0;
        m_addr    = '0;
        m_tid     = '0;
        last_dack = 0;
    endtask

    task automatic do_reset();
        rst_i = 1; flush_i = 0; dmd_req_i = 0; pf_req_i = 0; mem_ack_i = 0;
        mem_rtrn_vld_i = 0; dmd_addr_i = '0; dmd_tid_i = '0; pf_addr_i = '0;
        mem_rtrn_tid_i = '0; mem_rtrn_data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        model_reset();
        #1;
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_mem_addr", mem_addr_o, 0);
        chk("reset_mem_tid", mem_tid_o, 0);
    endtask

    // Compare all outputs with the reference for the current inputs, then
    // advance the reference across the coming clock edge.
    task automatic step(input string tag);
        bit pop, pf_ret, exp_pr, exp_drop, exp_dack, ack_pf, dd, pd;
        #1;
        exp_dack = (m_busy == 1) && mem_ack_i;
        pf_ret   = mem_rtrn_vld_i && (mem_rtrn_tid_i == TID_W'(PF_TID));
        exp_pr   = pf_ret && (m_discard == 0) && (m_pf_out > 0);
        pop      = (m_busy == 0) && !dmd_req_i && (m_q.size() > 0) &&
                   (m_pf_out + int'(m_stale) < MAX_PF_OUT) && !flush_i;
        exp_drop = pf_req_i && !flush_i && (m_q.size() == PFQ_DEPTH) && !pop;

        chk({tag, "_mem_req"}, mem_req_o, (m_busy != 0));
        if (m_busy != 0) begin
            chk({tag, "_mem_addr"}, mem_addr_o, m_addr);
            chk({tag, "_mem_tid"}, mem_tid_o, m_tid);
        end
        chk({tag, "_dmd_ack"}, dmd_ack_o, exp_dack);
        chk({tag, "_pf_drop"}, pf_drop_o, exp_drop);
        chk({tag, "_dmd_rtrn"}, dmd_rtrn_vld_o, mem_rtrn_vld_i && !pf_ret);
        chk({tag, "_pf_rtrn"}, pf_rtrn_vld_o, exp_pr);
        chk({tag, "_rtrn_data"}, rtrn_data_o, mem_rtrn_data_i);

        ack_pf = (m_busy == 2) && mem_ack_i;
        dd     = pf_ret && (m_discard > 0);
        pd     = exp_pr;
        if (flush_i) begin
            m_discard = m_discard - int'(dd) + m_pf_out - int'(pd) + int'(ack_pf);
            if (m_discard > DISC_SAT) m_discard = DISC_SAT;
            m_pf_out = 0;
            if (m_busy == 2 && !mem_ack_i) m_stale = 1;
            m_q.delete();
        end else begin
            m_pf_out  = m_pf_out + int'(ack_pf && !m_stale) - int'(pd);
            m_discard = m_discard + int'(ack_pf && m_stale) - int'(dd);
        end
        if (m_busy != 0 && mem_ack_i) begin
            m_busy  = 0;
            m_stale = 0;
        end else if (m_busy == 0) begin
            if (dmd_req_i) begin
                m_busy = 1; m_addr = dmd_addr_i; m_tid = dmd_tid_i;
            end else if (pop) begin
                m_busy = 2; m_addr = m_q.pop_front(); m_tid = TID_W'(PF_TID);
            end
        end
        if (pf_req_i && !flush_i && !exp_drop) m_q.push_back(pf_addr_i);
        last_dack = exp_dack;
        @(negedge clk_i);
    endtask

    task automatic wait_req(input string tag, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            #1;
            if (mem_req_o) seen = 1;
            else step(tag);
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic issue_pf_acked(input string tag, input logic [ADDR_W-1:0] a);
        pf_req_i = 1; pf_addr_i = a;
        step(tag);
        pf_req_i = 0;
        wait_req(tag, 6);
        chk({tag, "_addr"}, mem_addr_o, a);
        mem_ack_i = 1;
        step(tag);
        mem_ack_i = 0;
    endtask

    initial begin
        logic [TID_W-1:0] t;
        int n;

        tbl[0] = '{tid: 2'd0, data: {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}, exp_d: 1, exp_p: 0};
        tbl[1] = '{tid: 2'd2, data: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, exp_d: 1, exp_p: 0};
        tbl[2] = '{tid: 2'd3, data: '1, exp_d: 1, exp_p: 0};
        tbl[3] = '{tid: 2'd0, data: '0, exp_d: 1, exp_p: 0};

        // Demand request with a delayed ack.
        do_reset();
        dmd_req_i = 1; dmd_addr_i = 56'h8000_0040; dmd_tid_i = 0;
        step("t1");
        #1;
        chk("t1_req_cycle1", mem_req_o, 1);
        chk("t1_addr", mem_addr_o, 56'h8000_0040);
        step("t1"); step("t1");
        mem_ack_i = 1;
        #1;
        chk("t1_dmd_ack", dmd_ack_o, 1);
        step("t1");
        dmd_req_i = 0; mem_ack_i = 0;
        #1;
        chk("t1_idle", mem_req_o, 0);
        step("t1");

        // Prefetch burst, overflow, FIFO ordering and in-flight cap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pf_req_i = 1; pf_addr_i = 56'h1000 + 56'(16 * i);
            step("t2_push");
        end
        #1;
        chk("t2_first_addr", mem_addr_o, 56'h1000);
        chk("t2_first_tid", mem_tid_o, PF_TID);
        pf_addr_i = 56'h1050;
        #1;
        chk("t2_drop", pf_drop_o, 1);
        step("t2_ovf");
        pf_req_i = 0;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            #1;
            if (mem_req_o) begin
                chk("t2_order", mem_addr_o, 56'h1000 + 56'(16 * n));
                mem_ack_i = 1;
                n++;
            end
            step("t2_ack");
            mem_ack_i = 0;
        end
        if (n != 4) chk("t2_ack_timeout", n, 4);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t4_capped", mem_req_o, 0);
            step("t4_cap");
        end
        mem_rtrn_vld_i = 1; mem_rtrn_tid_i = PF_TID; mem_rtrn_data_i = 128'h55;
        #1;
        chk("t4_pf_rtrn", pf_rtrn_vld_o, 1);
        step("t4_rtrn");
        mem_rtrn_vld_i = 0;
        wait_req("t4_resume", 4);
        chk("t4_fifth_addr", mem_addr_o, 56'h1040);

        // Demand and prefetch pending together.
        do_reset();
        dmd_req_i = 1; dmd_addr_i = 56'hABC0; dmd_tid_i = 2;
        pf_req_i = 1; pf_addr_i = 56'h2000;
        step("t3");
        pf_req_i = 0; mem_ack_i = 1;
        #1;
        chk("t3_dmd_first", mem_tid_o, 2);
        step("t3");
        dmd_req_i = 0; mem_ack_i = 0;
        #1;
        chk("t3_idle_gap", mem_req_o, 0);
        step("t3");
        #1;
        chk("t3_pf_req", mem_req_o, 1);
        chk("t3_pf_addr", mem_addr_o, 56'h2000);
        step("t3");

        // Flush with two prefetches in flight and one on the bus.
        do_reset();
        issue_pf_acked("t5_a", 56'h3000);
        issue_pf_acked("t5_b", 56'h3010);
        pf_req_i = 1; pf_addr_i = 56'h3020;
        step("t5_c");
        pf_req_i = 0;
        wait_req("t5_c", 6);
        flush_i = 1;
        step("t5_flush");
        flush_i = 0;
        #1;
        chk("t5_held_after_flush", mem_req_o, 1);
        mem_ack_i = 1;
        step("t5_stale_ack");
        mem_ack_i = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rtrn_vld_i = 1; mem_rtrn_tid_i = PF_TID; mem_rtrn_data_i = 128'(i);
            #1;
            chk("t5_discarded", pf_rtrn_vld_o, 0);
            step("t5_disc");
        end
        mem_rtrn_vld_i = 0;
        issue_pf_acked("t5_d", 56'h3030);
        mem_rtrn_vld_i = 1; mem_rtrn_tid_i = PF_TID;
        #1;
        chk("t5_delivered", pf_rtrn_vld_o, 1);
        step("t5_deliv");
        mem_rtrn_vld_i = 0;

        // Demand return steering table.
        do_reset();
        foreach (tbl[i]) begin
            mem_rtrn_vld_i = 1; mem_rtrn_tid_i = tbl[i].tid; mem_rtrn_data_i = tbl[i].data;
            #1;
            chk("t6_dmd_vld", dmd_rtrn_vld_o, tbl[i].exp_d);
            chk("t6_pf_vld", pf_rtrn_vld_o, tbl[i].exp_p);
            chk("t6_data", rtrn_data_o, tbl[i].data);
            step("t6");
        end
        mem_rtrn_vld_i = 0;

        // Randomized traffic against the reference.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (dmd_req_i && last_dack) dmd_req_i = 0;
            if (!dmd_req_i && $urandom_range(0, 99) < 15) begin
                dmd_req_i  = 1;
                dmd_addr_i = {$urandom, $urandom};
                t = TID_W'($urandom_range(0, 2));
                dmd_tid_i  = (t >= 1) ? t + 1'b1 : t;
            end
            pf_req_i  = ($urandom_range(0, 99) < 40);
            pf_addr_i = {$urandom, $urandom};
            mem_ack_i = ($urandom_range(0, 99) < 50);
            flush_i   = ($urandom_range(0, 99) < 3);
            mem_rtrn_vld_i  = ($urandom_range(0, 99) < 30);
            mem_rtrn_data_i = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1 && (m_pf_out + m_discard) > 0) begin
                mem_rtrn_tid_i = PF_TID;
            end else begin
                t = TID_W'($urandom_range(0, 2));
                mem_rtrn_tid_i = (t >= 1) ? t + 1'b1 : t;
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
